map_mcart_rstsel: RTL



---
 rtl/map_mcart_rstsel_pkg.sv | 22 ++
 rtl/mcart_rst_cnt.sv | 39 +++
 rtl/map_mcart_rstsel.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/map_mcart_rstsel_pkg.sv
// Shared definitions for the reset-selected multicart mapper:
// save-state register indices, mirroring encodings and lock states.
package map_mcart_rstsel_pkg;

    localparam logic [7:0] SS_REG0 = 8'd0;
    localparam logic [7:0] SS_REG1 = 8'd1;
    localparam logic [7:0] SS_RCNT = 8'd2;
    localparam logic [7:0] SS_IDX  = 8'd127;

    typedef enum logic [1:0] {
        MIR_3SC  = 2'd0,
        MIR_VERT = 2'd1,
        MIR_HORZ = 2'd2,
        MIR_HIGH = 2'd3
    } mir_e;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_e;

endpackage

// File: rtl/mcart_rst_cnt.sv
// Soft-reset counter: advances once per rising map_rst level (seen on negedge m2).
// Ports: m2/sys_rst clocking, map_rst, ss_act/ss_ld/ss_wdat load, cnt value, rdat readback.
module mcart_rst_cnt #(
    parameter int W  = 2,
    parameter bit EN = 1'b1
) (
    input  logic         m2,
    input  logic         sys_rst,
    input  logic         map_rst,
    input  logic         ss_act,
    input  logic         ss_ld,
    input  logic [W-1:0] ss_wdat,
    output logic [W-1:0] cnt,
    output logic [7:0]   rdat
);

    logic mr_d;

    // mr_d keeps tracking map_rst during save-state access so that
    // a reset level already held when ss_act drops is not re-counted.
    always_ff @(negedge m2 or posedge sys_rst) begin
        if (sys_rst) begin
            cnt  <= '0;
            mr_d <= 1'b0;
        end else begin
            mr_d <= map_rst;
            if (ss_act) begin
                if (ss_ld) begin
                    cnt <= ss_wdat;
                end
            end else if (EN && map_rst && !mr_d) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rdat = 8'(cnt);

endmodule

// File: rtl/map_mcart_rstsel.sv
// Reset-selected multicart mapper: inner PRG bank, 16K/32K mode, mirroring,
// outer bank stepped by soft reset, lockable outer register, save-state port.
// Ports: m2, sys_rst, map_rst, CPU/PPU bus fields, ss_* save-state access,
// prg_addr/chr_addr/ciram_* /rom_ce/ram_ce outputs, prg_dat ROM data.
// Optional: define MCART_BUS_CONFLICT_EN to AND register writes with prg_dat.
module map_mcart_rstsel
    import map_mcart_rstsel_pkg::*;
#(
    parameter int         PRG_W   = 20,
    parameter int         OUTER_W = 2,
    parameter int         RST_SEL = 1,
    parameter logic [7:0] MAP_IDX = 8'd233
) (
    input  logic             m2,
    input  logic             sys_rst,
    input  logic             map_rst,
    input  logic [15:0]      cpu_addr,
    input  logic [7:0]       cpu_dat,
    input  logic             cpu_rw,
    input  logic [13:0]      ppu_addr,
    input  logic             ss_act,
    input  logic             ss_we,
    input  logic [7:0]       ss_addr,
    output logic [7:0]       ss_rdat,
    output logic [PRG_W-1:0] prg_addr,
    output logic [12:0]      chr_addr,
    output logic             ciram_a10,
    output logic             ciram_ce,
    output logic             rom_ce,
    output logic             ram_ce,
    input  logic [7:0]       prg_dat
);

    localparam int IW_RAW = PRG_W - 14 - OUTER_W;
    localparam int IW     = (IW_RAW < 1) ? 1 : IW_RAW;

    logic [7:0]         reg0_q, reg0_d;
    logic [OUTER_W-1:0] outer_q, outer_d;
    lock_e              lock_q, lock_d;
    logic [OUTER_W-1:0] rst_cnt;
    logic [7:0]         cnt_rdat;
    logic [7:0]         wdat;
    logic               cpu_wr;
    logic               ss_wr;

`ifdef MCART_BUS_CONFLICT_EN
    assign wdat = cpu_dat & prg_dat;
`else
    logic unused_prg;
    assign wdat       = cpu_dat;
    assign unused_prg = ^prg_dat;
`endif

    assign cpu_wr = !cpu_rw && cpu_addr[15];
    assign ss_wr  = ss_act && ss_we;

    always_ff @(negedge m2 or posedge sys_rst) begin
        if (sys_rst) begin
            reg0_q  <= '0;
            outer_q <= '0;
            lock_q  <= UNLOCKED;
        end else begin
            reg0_q  <= reg0_d;
            outer_q <= outer_d;
            lock_q  <= lock_d;
        end
    end

    // Priority: save-state access, then soft reset, then CPU write.
    always_comb begin
        reg0_d  = reg0_q;
        outer_d = outer_q;
        lock_d  = lock_q;
        if (ss_act) begin
            if (ss_we && ss_addr == SS_REG0) begin
                reg0_d = cpu_dat;
            end
            if (ss_we && ss_addr == SS_REG1) begin
                outer_d = cpu_dat[OUTER_W-1:0];
                lock_d  = cpu_dat[7] ? LOCKED : UNLOCKED;
            end
        end else if (map_rst) begin
            reg0_d  = '0;
            outer_d = '0;
            lock_d  = UNLOCKED;
        end else if (cpu_wr) begin
            if (!cpu_addr[0]) begin
                reg0_d = wdat;
            end else begin
                unique case (lock_q)
                    UNLOCKED: begin
                        outer_d = wdat[OUTER_W-1:0];
                        lock_d  = wdat[7] ? LOCKED : UNLOCKED;
                    end
                    LOCKED: begin
                        outer_d = outer_q;
                    end
                endcase
            end
        end
    end

    mcart_rst_cnt #(
        .W  (OUTER_W),
        .EN (RST_SEL != 0)
    ) u_rst_cnt (
        .m2      (m2),
        .sys_rst (sys_rst),
        .map_rst (map_rst),
        .ss_act  (ss_act),
        .ss_ld   (ss_wr && ss_addr == SS_RCNT),
        .ss_wdat (cpu_dat[OUTER_W-1:0]),
        .cnt     (rst_cnt),
        .rdat    (cnt_rdat)
    );

    logic [OUTER_W-1:0] outer;

    generate
        if (RST_SEL != 0) begin : g_rst_sel
            assign outer = rst_cnt ^ outer_q;
        end else begin : g_reg_only
            assign outer = outer_q;
        end
    endgenerate

    logic [IW+4:0]             inner_x;
    logic [IW-1:0]             bank;
    logic [OUTER_W+IW+13:0]    prg_full;

    assign inner_x = {{IW{1'b0}}, reg0_q[4:0]};

    // 16K mode uses the full inner bank; 32K mode lets A14 pick the half.
    always_comb begin
        bank = inner_x[IW-1:0];
        if (!reg0_q[5]) begin
            bank[0] = cpu_addr[14];
        end
    end

    assign prg_full = {outer, bank, cpu_addr[13:0]};
    assign prg_addr = prg_full[PRG_W-1:0];

    mir_e mir;
    assign mir = mir_e'(reg0_q[7:6]);

    always_comb begin
        ciram_a10 = 1'b0;
        unique case (mir)
            MIR_3SC:  ciram_a10 = &ppu_addr[11:10];
            MIR_VERT: ciram_a10 = ppu_addr[10];
            MIR_HORZ: ciram_a10 = ppu_addr[11];
            MIR_HIGH: ciram_a10 = 1'b1;
        endcase
    end

    assign chr_addr = ppu_addr[12:0];
    assign ciram_ce = !ppu_addr[13];
    assign rom_ce   = cpu_addr[15];
    assign ram_ce   = (cpu_addr[15:13] == 3'b011);

    always_comb begin
        ss_rdat = 8'hFF;
        case (ss_addr)
            SS_REG0: ss_rdat = reg0_q;
            SS_REG1: ss_rdat = {lock_q == LOCKED, 7'(outer_q)};
            SS_RCNT: ss_rdat = cnt_rdat;
            SS_IDX:  ss_rdat = MAP_IDX;
            default: ss_rdat = 8'hFF;
        endcase
    end

endmodule
